// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared types, field widths and defaults for the alarm controller
package alarm_ctrl_pkg;
  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int TIMER_W  = 9;
  localparam int SNOOZE_W = 2;

  localparam int DEF_RING_TIMEOUT_S = 60;
  localparam int DEF_SNOOZE_S       = 300;
  localparam int DEF_MAX_SNOOZE     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RINGING,
    ST_SNOOZE
  } alarm_state_t;
endpackage

// File: rtl/alarm_ctrl_tick_down_counter.sv
// rtl/alarm_ctrl_tick_down_counter.sv - loadable down-counter that holds at zero
module tick_down_counter
  import alarm_ctrl_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);
  assign zero = (count == '0);

  // load beats enable; enable at zero is a no-op so the count never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && !zero)
      count <= count - W'(1);
  end
endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm clock controller: match detect, ring timeout, snooze and buzzer
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
  parameter int SNOOZE_S       = DEF_SNOOZE_S,
  parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_1hz,
  input  logic [HOUR_W-1:0]   cur_hour,
  input  logic [MIN_W-1:0]    cur_min,
  input  logic [SEC_W-1:0]    cur_sec,
  input  logic [HOUR_W-1:0]   set_hour,
  input  logic [MIN_W-1:0]    set_min,
  input  logic                set_alarm,
  input  logic                alarm_en,
  input  logic                btn_stop,
  input  logic                btn_snooze,
  output logic [HOUR_W-1:0]   alm_hour,
  output logic [MIN_W-1:0]    alm_min,
  output logic                ringing,
  output logic                buzz,
  output logic                snoozing,
  output logic [SNOOZE_W-1:0] snooze_left
);
  localparam int TMAX = (1 << TIMER_W) - 1;

  if (RING_TIMEOUT_S < 1 || RING_TIMEOUT_S > TMAX) begin : g_bad_ring
    $error("RING_TIMEOUT_S must be 1..511");
  end
  if (SNOOZE_S < 1 || SNOOZE_S > TMAX) begin : g_bad_snooze
    $error("SNOOZE_S must be 1..511");
  end
  if (MAX_SNOOZE < 0 || MAX_SNOOZE > (1 << SNOOZE_W) - 1) begin : g_bad_max
    $error("MAX_SNOOZE does not fit snooze_left");
  end

  localparam logic [TIMER_W-1:0]  RING_LD   = TIMER_W'(RING_TIMEOUT_S);
  localparam logic [TIMER_W-1:0]  SNOOZE_LD = TIMER_W'(SNOOZE_S);
  localparam logic [SNOOZE_W-1:0] LEFT_LD   = SNOOZE_W'(MAX_SNOOZE);

  alarm_state_t        state, state_n;
  logic                match, match_q, trigger;
  logic                phase, phase_n;
  logic [SNOOZE_W-1:0] left_n;
  logic                tmr_load, tmr_en, tmr_zero, tmr_done;
  logic [TIMER_W-1:0]  tmr_val, tmr_count;

  assign match    = (cur_hour == alm_hour) && (cur_min == alm_min) && (cur_sec == '0);
  assign trigger  = match && !match_q;
  assign tmr_done = tmr_zero || (tmr_count == TIMER_W'(1));

  // match_q starts high so a reset landing on the alarm minute cannot fire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alm_hour <= '0;
      alm_min  <= '0;
      match_q  <= 1'b1;
    end else begin
      if (set_alarm) begin
        alm_hour <= set_hour;
        alm_min  <= set_min;
      end
      match_q <= match;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase       <= 1'b0;
      snooze_left <= '0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      snooze_left <= left_n;
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    left_n   = snooze_left;
    tmr_load = 1'b0;
    tmr_val  = RING_LD;
    tmr_en   = 1'b0;
    if (!alarm_en) begin
      state_n = ST_IDLE;
      left_n  = '0;
    end else begin
      case (state)
        ST_IDLE: state_n = ST_ARMED;
        ST_ARMED: begin
          if (trigger) begin
            state_n  = ST_RINGING;
            tmr_load = 1'b1;
            left_n   = LEFT_LD;
            phase_n  = 1'b1;
          end
        end
        ST_RINGING: begin
          if (btn_stop) begin
            state_n = ST_ARMED;
          end else if (btn_snooze && snooze_left != '0) begin
            state_n  = ST_SNOOZE;
            tmr_load = 1'b1;
            tmr_val  = SNOOZE_LD;
            left_n   = snooze_left - SNOOZE_W'(1);
          end else if (tick_1hz) begin
            tmr_en  = 1'b1;
            phase_n = !phase;
            if (tmr_done) state_n = ST_ARMED;
          end
        end
        ST_SNOOZE: begin
          if (btn_stop) begin
            state_n = ST_ARMED;
          end else if (tick_1hz) begin
            if (tmr_done) begin
              state_n  = ST_RINGING;
              tmr_load = 1'b1;
              phase_n  = 1'b1;
            end else begin
              tmr_en = 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  tick_down_counter #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  assign ringing  = (state == ST_RINGING);
  assign snoozing = (state == ST_SNOOZE);
  assign buzz     = ringing && phase;
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - self-checking bench for alarm_ctrl against a behavioural model
module tb_alarm_ctrl;
  localparam int RING_S   = 60;
  localparam int SNOOZE_S = 300;
  localparam int MAXS     = 3;

  localparam int OFF  = 0;
  localparam int WAIT = 1;
  localparam int RING = 2;
  localparam int SNZ  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [4:0] cur_hour, set_hour, alm_hour;
  logic [5:0] cur_min, cur_sec, set_min, alm_min;
  logic       set_alarm, alarm_en, btn_stop, btn_snooze;
  logic       ringing, buzz, snoozing;
  logic [1:0] snooze_left;

  alarm_ctrl #(.RING_TIMEOUT_S(RING_S), .SNOOZE_S(SNOOZE_S), .MAX_SNOOZE(MAXS)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .set_hour    (set_hour),
    .set_min     (set_min),
    .set_alarm   (set_alarm),
    .alarm_en    (alarm_en),
    .btn_stop    (btn_stop),
    .btn_snooze  (btn_snooze),
    .alm_hour    (alm_hour),
    .alm_min     (alm_min),
    .ringing     (ringing),
    .buzz        (buzz),
    .snoozing    (snoozing),
    .snooze_left (snooze_left)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // behavioural model: mode, seconds remaining, buzzer phase, snoozes left, stored alarm
  int m_mode, m_secs, m_left, m_ah, m_am;
  bit m_phase, m_prev_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = OFF; m_secs = 0; m_left = 0; m_ah = 0; m_am = 0;
    m_phase = 1'b0; m_prev_at = 1'b1;
  endtask

  task automatic model_step();
    bit at_alarm, fire;
    if (reset) begin
      model_reset();
      return;
    end
    at_alarm  = (int'(cur_hour) == m_ah) && (int'(cur_min) == m_am) && (cur_sec == 0);
    fire      = at_alarm && !m_prev_at;
    m_prev_at = at_alarm;
    if (set_alarm) begin
      m_ah = int'(set_hour);
      m_am = int'(set_min);
    end
    if (!alarm_en) begin
      m_mode = OFF;
      m_left = 0;
    end else if (m_mode == OFF) begin
      m_mode = WAIT;
    end else if (m_mode == WAIT) begin
      if (fire) begin
        m_mode = RING; m_secs = RING_S; m_left = MAXS; m_phase = 1'b1;
      end
    end else if (m_mode == RING) begin
      if (btn_stop) m_mode = WAIT;
      else if (btn_snooze && m_left > 0) begin
        m_mode = SNZ; m_secs = SNOOZE_S; m_left = m_left - 1;
      end else if (tick_1hz) begin
        m_phase = !m_phase;
        if (m_secs <= 1) m_mode = WAIT;
        if (m_secs > 0) m_secs = m_secs - 1;
      end
    end else begin
      if (btn_stop) m_mode = WAIT;
      else if (tick_1hz) begin
        if (m_secs <= 1) begin
          m_mode = RING; m_secs = RING_S; m_phase = 1'b1;
        end else m_secs = m_secs - 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ringing",     ringing,     m_mode == RING);
      chk("snoozing",    snoozing,    m_mode == SNZ);
      chk("buzz",        buzz,        (m_mode == RING) && m_phase);
      chk("snooze_left", snooze_left, m_left);
      chk("alm_hour",    alm_hour,    m_ah);
      chk("alm_min",     alm_min,     m_am);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick_1hz = 0; btn_stop = 0; btn_snooze = 0; set_alarm = 0;
  endtask

  task automatic tick_sec();
    tick_1hz = 1;
    cyc();
    cyc();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  task automatic fire_0730();
    set_time(7, 30, 1); cyc();
    set_time(7, 30, 0); cyc();
    set_time(7, 30, 1); cyc();
  endtask

  int rings;

  initial begin
    reset = 1; tick_1hz = 0; set_alarm = 0; alarm_en = 0; btn_stop = 0; btn_snooze = 0;
    set_hour = 0; set_min = 0; set_time(0, 0, 0);
    model_reset();
    chk_on = 1'b1;
    cyc(); cyc();
    chk("rst_ringing", ringing, 0);
    chk("rst_snoozing", snoozing, 0);
    chk("rst_buzz", buzz, 0);
    chk("rst_left", snooze_left, 0);
    chk("rst_alm", {alm_hour, alm_min}, 0);

    // alarm register is 00:00 and time is 00:00:00 out of reset: no alarm
    reset = 0; alarm_en = 1;
    cyc(); cyc(); cyc();
    chk("no_fire_after_reset", ringing, 0);

    set_hour = 7; set_min = 30; set_alarm = 1; cyc();
    chk("alm_hour_set", alm_hour, 7);
    chk("alm_min_set", alm_min, 30);

    set_time(7, 29, 59); cyc();
    set_time(7, 30, 0); cyc();
    chk("ring_start", ringing, 1);
    chk("buzz_start", buzz, 1);
    chk("left_start", snooze_left, 3);
    set_time(7, 30, 1);
    tick_sec();
    chk("buzz_tick1", buzz, 0);
    tick_sec();
    chk("buzz_tick2", buzz, 1);
    repeat (57) tick_sec();
    chk("ring_59", ringing, 1);
    tick_sec();
    chk("ring_timeout", ringing, 0);

    // time held at the alarm minute for several cycles fires once
    set_time(7, 30, 0);
    repeat (5) cyc();
    chk("hold_ring", ringing, 1);
    btn_stop = 1; cyc();
    repeat (3) cyc();
    chk("hold_no_refire", ringing, 0);
    set_time(7, 30, 1); cyc();
    set_time(7, 30, 0); cyc();
    chk("next_day_fire", ringing, 1);
    btn_stop = 1; cyc();
    set_time(7, 30, 1); cyc();

    fire_0730();
    for (int k = 0; k < 3; k++) begin
      btn_snooze = 1; cyc();
      chk("snoozing", snoozing, 1);
      chk("snooze_left_dec", snooze_left, 2 - k);
      repeat (299) tick_sec();
      chk("snooze_299", snoozing, 1);
      tick_sec();
      chk("snooze_expire_ring", ringing, 1);
      chk("snooze_expire_buzz", buzz, 1);
    end
    btn_snooze = 1; cyc();
    chk("snooze4_ignored_ring", ringing, 1);
    chk("snooze4_ignored_left", snooze_left, 0);
    btn_stop = 1; cyc();

    fire_0730();
    btn_stop = 1; btn_snooze = 1; cyc();
    chk("stop_wins_ring", ringing, 0);
    chk("stop_wins_snz", snoozing, 0);
    chk("stop_wins_left", snooze_left, 3);

    fire_0730();
    btn_snooze = 1; cyc();
    tick_sec();
    alarm_en = 0; cyc();
    chk("en_low_snz", snoozing, 0);
    chk("en_low_ring", ringing, 0);
    chk("en_low_left", snooze_left, 0);
    alarm_en = 1; cyc();

    fire_0730();
    tick_sec();
    #2 reset = 1;
    #1;
    chk("async_rst_ring", ringing, 0);
    chk("async_rst_buzz", buzz, 0);
    model_reset();
    cyc();
    reset = 0;
    cyc();

    set_hour = 25; set_min = 0; set_alarm = 1; cyc();
    chk("alm_hour_25", alm_hour, 25);
    rings = 0;
    for (int h = 0; h < 24; h++) begin
      for (int m = 0; m < 60; m++) begin
        set_time(h, m, 0); cyc();
        if (ringing) rings++;
        set_time(h, m, 1); cyc();
        if (ringing) rings++;
      end
    end
    chk("day_no_ring", rings, 0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
